// File: rtl/spi_share_pkg.sv
// Shared types and constants for the SPI master sharing controller.
package spi_share_pkg;

    localparam int DEF_N_REQ   = 3;
    localparam int DEF_DATA_W  = 8;
    localparam int DEF_CLK_DIV = 2;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        DONE
    } state_t;

    // Bits needed to count 0..value-1; never less than one bit.
    function automatic int clog2(input int value);
        int width;
        width = 1;
        while ((1 << width) < value) begin
            width = width + 1;
        end
        return width;
    endfunction

endpackage

// File: rtl/spi_share_ctrl_rr_arbiter.sv
// Combinational requester arbiter for spi_share_ctrl.
// Build option: define SPI_SHARE_FIXED_PRIO_EN for fixed lowest-index-wins
// priority; otherwise round-robin starting after the last granted requester.
module rr_arbiter
    import spi_share_pkg::*;
#(
    parameter  int N_REQ = DEF_N_REQ,
    localparam int IDX_W = clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_last_grant,
    output logic [N_REQ-1:0] o_winner,
    output logic [IDX_W-1:0] o_winner_idx
);

    logic [IDX_W-1:0] w_cand;

`ifdef SPI_SHARE_FIXED_PRIO_EN
    logic w_unused_last_grant;
    assign w_unused_last_grant = ^i_last_grant;

    // Fixed priority: scan high to low so the lowest set index is written last.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        o_winner     = '0;
        o_winner_idx = '0;
        w_cand       = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_cand = IDX_W'(k);
            if (i_req[w_cand]) begin
                o_winner         = '0;
                o_winner[w_cand] = 1'b1;
                o_winner_idx     = w_cand;
            end
        end
    end
`else
    // Round-robin: scan from the farthest candidate back to last_grant+1 so the
    // nearest set request after the previous winner is written last.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        o_winner     = '0;
        o_winner_idx = '0;
        w_cand       = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            w_cand = IDX_W'((int'(i_last_grant) + k) % N_REQ);
            if (i_req[w_cand]) begin
                o_winner         = '0;
                o_winner[w_cand] = 1'b1;
                o_winner_idx     = w_cand;
            end
        end
    end
`endif

endmodule

// File: rtl/spi_share_ctrl.sv
// Shares one SPI mode-0 master port between N_REQ requesters: arbitrates in
// IDLE, then runs one MSB-first DATA_W-bit transfer for the winner.
// Build option: SPI_SHARE_FIXED_PRIO_EN selects fixed priority in rr_arbiter.
module spi_share_ctrl
    import spi_share_pkg::*;
#(
    parameter int N_REQ   = DEF_N_REQ,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic                      clk_clk,
    input  logic                      reset_reset_n,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*DATA_W-1:0]   wdata,
    output logic [N_REQ-1:0]          gnt,
    output logic [N_REQ-1:0]          done,
    output logic [DATA_W-1:0]         rdata,
    output logic                      busy,
    output logic                      spi_sclk,
    output logic                      spi_mosi,
    output logic                      spi_ss_n,
    input  logic                      spi_miso
);

    localparam int IDX_W   = clog2(N_REQ);
    localparam int PHASE_W = clog2(2 * DATA_W);
    localparam int DIV_W   = clog2(CLK_DIV);

    localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(2 * DATA_W - 1);
    localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0]   GRANT_INIT = IDX_W'(N_REQ - 1);

    state_t              r_state,      w_state_nxt;
    logic [IDX_W-1:0]    r_last_grant, w_last_grant_nxt;
    logic [N_REQ-1:0]    r_gnt,        w_gnt_nxt;
    logic [N_REQ-1:0]    r_done,       w_done_nxt;
    logic [DATA_W-1:0]   r_rdata,      w_rdata_nxt;
    logic                r_busy,       w_busy_nxt;
    logic                r_sclk,       w_sclk_nxt;
    logic                r_mosi,       w_mosi_nxt;
    logic                r_ss_n,       w_ss_n_nxt;
    logic [DATA_W-1:0]   r_tx,         w_tx_nxt;
    logic [DATA_W-1:0]   r_rx,         w_rx_nxt;
    logic [DIV_W-1:0]    r_div,        w_div_nxt;
    logic [PHASE_W-1:0]  r_phase,      w_phase_nxt;

    logic [N_REQ-1:0]    w_win;
    logic [IDX_W-1:0]    w_win_idx;
    logic [DATA_W-1:0]   w_wdata_sel;
    logic                w_div_last;

    rr_arbiter #(
        .N_REQ(N_REQ)
    ) u_arb (
        .i_req        (req),
        .i_last_grant (r_last_grant),
        .o_winner     (w_win),
        .o_winner_idx (w_win_idx)
    );

    assign w_wdata_sel = wdata[int'(w_win_idx) * DATA_W +: DATA_W];
    assign w_div_last  = (r_div == DIV_LAST);

    // State and datapath registers; every output is a flop so the SPI pins are glitch-free.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_state      <= IDLE;
            r_last_grant <= GRANT_INIT;
            r_gnt        <= '0;
            r_done       <= '0;
            r_rdata      <= '0;
            r_busy       <= 1'b0;
            r_sclk       <= 1'b0;
            r_mosi       <= 1'b0;
            r_ss_n       <= 1'b1;
            r_tx         <= '0;
            r_rx         <= '0;
            r_div        <= '0;
            r_phase      <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            r_state      <= w_state_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_gnt        <= w_gnt_nxt;
            r_done       <= w_done_nxt;
            r_rdata      <= w_rdata_nxt;
            r_busy       <= w_busy_nxt;
            r_sclk       <= w_sclk_nxt;
            r_mosi       <= w_mosi_nxt;
            r_ss_n       <= w_ss_n_nxt;
            r_tx         <= w_tx_nxt;
            r_rx         <= w_rx_nxt;
            r_div        <= w_div_nxt;
            r_phase      <= w_phase_nxt;
        end
    end

    // Next-state and next-output logic; every register holds unless a state changes it.
    always_comb begin
        w_state_nxt      = r_state;
        w_last_grant_nxt = r_last_grant;
        w_gnt_nxt        = r_gnt;
        w_done_nxt       = '0;
        w_rdata_nxt      = r_rdata;
        w_busy_nxt       = r_busy;
        w_sclk_nxt       = r_sclk;
        w_mosi_nxt       = r_mosi;
        w_ss_n_nxt       = r_ss_n;
        w_tx_nxt         = r_tx;
        w_rx_nxt         = r_rx;
        w_div_nxt        = r_div;
        w_phase_nxt      = r_phase;

        case (r_state)
            IDLE: begin
                if (|req) begin
                    w_state_nxt      = SETUP;
                    w_gnt_nxt        = w_win;
                    w_last_grant_nxt = w_win_idx;
                    w_tx_nxt         = w_wdata_sel;
                    w_mosi_nxt       = w_wdata_sel[DATA_W-1];
                    w_ss_n_nxt       = 1'b0;
                    w_busy_nxt       = 1'b1;
                    w_div_nxt        = '0;
                end
            end

            SETUP: begin
                if (w_div_last) begin
                    // Entering phase 0: first rising SCLK edge, sample MISO.
                    w_state_nxt = SHIFT;
                    w_div_nxt   = '0;
                    w_phase_nxt = '0;
                    w_sclk_nxt  = 1'b1;
                    w_rx_nxt    = {r_rx[DATA_W-2:0], spi_miso};
                end else begin
                    w_div_nxt = r_div + DIV_W'(1);
                end
            end

            SHIFT: begin
                if (w_div_last) begin
                    w_div_nxt = '0;
                    if (r_phase == LAST_PHASE) begin
                        w_state_nxt = HOLD;
                    end else begin
                        w_phase_nxt = r_phase + PHASE_W'(1);
                        if (!r_phase[0]) begin
                            // Entering an odd phase: SCLK falls, present the next bit.
                            w_sclk_nxt = 1'b0;
                            w_tx_nxt   = {r_tx[DATA_W-2:0], 1'b0};
                            w_mosi_nxt = r_tx[DATA_W-2];
                        end else begin
                            // Entering an even phase: SCLK rises, sample MISO.
                            w_sclk_nxt = 1'b1;
                            w_rx_nxt   = {r_rx[DATA_W-2:0], spi_miso};
                        end
                    end
                end else begin
                    w_div_nxt = r_div + DIV_W'(1);
                end
            end

            HOLD: begin
                if (w_div_last) begin
                    w_state_nxt = DONE;
                    w_div_nxt   = '0;
                    w_done_nxt  = r_gnt;
                    w_rdata_nxt = r_rx;
                    w_ss_n_nxt  = 1'b1;
                    w_gnt_nxt   = '0;
                end else begin
                    w_div_nxt = r_div + DIV_W'(1);
                end
            end

            DONE: begin
                w_state_nxt = IDLE;
                w_busy_nxt  = 1'b0;
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign gnt      = r_gnt;
    assign done     = r_done;
    assign rdata    = r_rdata;
    assign busy     = r_busy;
    assign spi_sclk = r_sclk;
    assign spi_mosi = r_mosi;
    assign spi_ss_n = r_ss_n;

endmodule
